// File: rtl/axis_rr_mux.sv
// axis_rr_mux: N-to-1 AXI-Stream mux with packet-level round-robin arbitration.
// Ports: aclk/areset (sync, active-high); s_* per-channel slave streams packed
// channel i at [i*W +: W]; m_* master stream driven from a 2-entry output
// buffer; grant_valid/grant_ch expose the current grant; pkt_cnt counts
// packets completed on the master side.
module axis_rr_mux #(
    parameter int DATA_SIZE = 32,
    parameter int ID_SIZE   = 4,
    parameter int NUM_CH    = 4,
    parameter int USE_CH_ID = 1,
    localparam int KW = DATA_SIZE / 8,
    localparam int CW = $clog2(NUM_CH)
) (
    input  logic                      aclk,
    input  logic                      areset,
    input  logic [NUM_CH-1:0]         s_tvalid,
    output logic [NUM_CH-1:0]         s_tready,
    input  logic [NUM_CH-1:0]         s_tlast,
    input  logic [NUM_CH*DATA_SIZE-1:0] s_tdata,
    input  logic [NUM_CH*ID_SIZE-1:0] s_tid,
    input  logic [NUM_CH*KW-1:0]      s_tkeep,
    input  logic [NUM_CH*KW-1:0]      s_tstrb,
    output logic                      m_tvalid,
    output logic                      m_tlast,
    input  logic                      m_tready,
    output logic [DATA_SIZE-1:0]      m_tdata,
    output logic [ID_SIZE-1:0]        m_tid,
    output logic [KW-1:0]             m_tkeep,
    output logic [KW-1:0]             m_tstrb,
    output logic                      grant_valid,
    output logic [CW-1:0]             grant_ch,
    output logic [15:0]               pkt_cnt
);
    localparam int EW = DATA_SIZE + ID_SIZE + 2 * KW + 1;
    typedef enum logic {IDLE, BUSY} state_t;
    state_t state;
    logic [CW-1:0] last_grant, winner, cand;
    logic [EW-1:0] buf0, buf1, in_beat;
    logic [ID_SIZE-1:0] in_tid;
    logic [1:0] buf_count;
    logic accept, pop, room;
    // Walk downwards so the nearest channel after last_grant wins.
    always_comb begin
        winner = last_grant;
        cand = last_grant;
        for (int i = NUM_CH; i >= 1; i--) begin
            cand = CW'((int'(last_grant) + i) % NUM_CH);
            if (s_tvalid[cand]) winner = cand;
        end
    end
    // Ready depends only on registered state, never on m_tready.
    assign room = buf_count < 2'd2;
    always_comb begin
        s_tready = '0;
        if (state == BUSY && room) s_tready[grant_ch] = 1'b1;
    end
    assign accept = state == BUSY && room && s_tvalid[grant_ch];
    assign in_tid = USE_CH_ID != 0 ? ID_SIZE'(grant_ch) : s_tid[grant_ch*ID_SIZE +: ID_SIZE];
    assign in_beat = {s_tdata[grant_ch*DATA_SIZE +: DATA_SIZE], in_tid,
                      s_tkeep[grant_ch*KW +: KW], s_tstrb[grant_ch*KW +: KW], s_tlast[grant_ch]};
    assign {m_tdata, m_tid, m_tkeep, m_tstrb, m_tlast} = buf0;
    assign m_tvalid = buf_count != 2'd0;
    assign pop = m_tvalid && m_tready;
    always_ff @(posedge aclk) begin
        if (areset) begin
            state       <= IDLE;
            grant_valid <= 1'b0;
            grant_ch    <= '0;
            last_grant  <= CW'(NUM_CH - 1);
            buf0        <= '0;
            buf1        <= '0;
            buf_count   <= '0;
            pkt_cnt     <= '0;
        end else begin
            if (state == IDLE) begin
                if (|s_tvalid) begin
                    state       <= BUSY;
                    grant_valid <= 1'b1;
                    grant_ch    <= winner;
                    last_grant  <= winner;
                end
            end else if (accept && s_tlast[grant_ch]) begin
                state       <= IDLE;
                grant_valid <= 1'b0;
            end
            // A push alongside a pop can only happen with one entry held,
            // so the new beat becomes the head directly.
            if (accept) begin
                if (buf_count == 2'd0 || pop) buf0 <= in_beat;
                else buf1 <= in_beat;
            end else if (pop) begin
                buf0 <= buf1;
            end
            buf_count <= buf_count + {1'b0, accept} - {1'b0, pop};
            if (pop && m_tlast) pkt_cnt <= pkt_cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_axis_rr_mux.sv
// tb_axis_rr_mux: directed bench for axis_rr_mux (channel-id and tid-passthrough builds).
module tb_axis_rr_mux;
    logic         aclk = 1'b0;
    logic         areset = 1'b1;
    logic [3:0]   s_tvalid, s_tlast, s_tready, s_tready0;
    logic [127:0] s_tdata;
    logic [15:0]  s_tid, s_tkeep, s_tstrb;
    logic         m_tready;
    logic         m_tvalid, m_tlast, grant_valid, m_tvalid0, m_tlast0, grant_valid0;
    logic [31:0]  m_tdata, m_tdata0;
    logic [3:0]   m_tid, m_tkeep, m_tstrb, m_tid0, m_tkeep0, m_tstrb0;
    logic [1:0]   grant_ch, grant_ch0;
    logic [15:0]  pkt_cnt, pkt_cnt0;

    axis_rr_mux #(.DATA_SIZE(32), .ID_SIZE(4), .NUM_CH(4), .USE_CH_ID(1)) dut (
        .aclk(aclk), .areset(areset), .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast),
        .s_tdata(s_tdata), .s_tid(s_tid), .s_tkeep(s_tkeep), .s_tstrb(s_tstrb),
        .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready), .m_tdata(m_tdata),
        .m_tid(m_tid), .m_tkeep(m_tkeep), .m_tstrb(m_tstrb),
        .grant_valid(grant_valid), .grant_ch(grant_ch), .pkt_cnt(pkt_cnt));

    axis_rr_mux #(.DATA_SIZE(32), .ID_SIZE(4), .NUM_CH(4), .USE_CH_ID(0)) dut0 (
        .aclk(aclk), .areset(areset), .s_tvalid(s_tvalid), .s_tready(s_tready0), .s_tlast(s_tlast),
        .s_tdata(s_tdata), .s_tid(s_tid), .s_tkeep(s_tkeep), .s_tstrb(s_tstrb),
        .m_tvalid(m_tvalid0), .m_tlast(m_tlast0), .m_tready(m_tready), .m_tdata(m_tdata0),
        .m_tid(m_tid0), .m_tkeep(m_tkeep0), .m_tstrb(m_tstrb0),
        .grant_valid(grant_valid0), .grant_ch(grant_ch0), .pkt_cnt(pkt_cnt0));

    always #5 aclk = ~aclk;

    typedef struct {
        logic [3:0]  vld;
        logic [3:0]  lst;
        logic [31:0] dat;
        logic [3:0]  srdy;
        logic        gv;
        logic [1:0]  gch;
        logic        mv;
        logic [31:0] md;
        logic        ml;
        logic [15:0] pc;
    } vec_t;

    int n_run = 0;
    int n_fail = 0;
    int cyc = 0;
    bit auto_src = 1'b0;
    bit en[4];
    int len[4], npk[4], pkt[4], beat[4];
    logic [3:0] tidv[4], keepv[4];
    logic [3:0] hs;
    logic [3:0] q_tid[$];
    logic [31:0] q_dat[$];
    logic q_last[$];

    function automatic logic [31:0] mkdat(int ch, int p, int b);
        return {8'(ch), 8'(p), 16'(b)};
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive_src();
        for (int c = 0; c < 4; c++) begin
            s_tvalid[c] = en[c] && pkt[c] < npk[c];
            s_tlast[c] = beat[c] == len[c] - 1;
            s_tdata[c*32 +: 32] = mkdat(c, pkt[c], beat[c]);
            s_tid[c*4 +: 4] = tidv[c];
            s_tkeep[c*4 +: 4] = keepv[c];
            s_tstrb[c*4 +: 4] = keepv[c];
        end
    endtask

    task automatic reset_src();
        for (int c = 0; c < 4; c++) begin
            en[c] = 1'b0; len[c] = 1; npk[c] = 0; pkt[c] = 0; beat[c] = 0;
            tidv[c] = 4'(c + 5); keepv[c] = 4'hF;
        end
        drive_src();
    endtask

    // One clock: record handshakes before the edge, settle 1 time unit after it.
    task automatic tick();
        hs = s_tvalid & s_tready;
        if (m_tvalid && m_tready) begin
            q_tid.push_back(m_tid); q_dat.push_back(m_tdata); q_last.push_back(m_tlast);
        end
        @(posedge aclk);
        #1;
        cyc++;
        if (auto_src) begin
            for (int c = 0; c < 4; c++) begin
                if (hs[c]) begin
                    if (beat[c] == len[c] - 1) begin beat[c] = 0; pkt[c]++; end
                    else beat[c]++;
                end
            end
            drive_src();
        end
    endtask

    task automatic do_reset();
        areset = 1'b1;
        reset_src();
        tick(); tick();
        areset = 1'b0;
        reset_src();
        q_tid.delete(); q_dat.delete(); q_last.delete();
    endtask

    task automatic run_until(int n, int budget);
        int k = 0;
        while (q_dat.size() < n && k < budget) begin tick(); k++; end
        chk("run_timeout", q_dat.size() >= n, 1);
    endtask

    task automatic chk_beat(int idx, int ch, int p, int b, logic lst);
        if (idx >= q_dat.size()) begin chk($sformatf("beat%0d_present", idx), 0, 1); return; end
        chk($sformatf("beat%0d_tid", idx), q_tid[idx], ch);
        chk($sformatf("beat%0d_data", idx), q_dat[idx], mkdat(ch, p, b));
        chk($sformatf("beat%0d_last", idx), q_last[idx], lst);
    endtask

    vec_t tv[7];
    int first_v, last_v, k;
    logic stalled;
    logic [31:0] snap_d;
    logic [3:0] snap_t;
    logic snap_l;

    initial begin
        m_tready = 1'b1;
        do_reset();
        // Reset state
        chk("rst_m_tvalid", m_tvalid, 0);
        chk("rst_s_tready", s_tready, 0);
        chk("rst_grant_valid", grant_valid, 0);
        chk("rst_grant_ch", grant_ch, 0);
        chk("rst_pkt_cnt", pkt_cnt, 0);
        chk("rst_m_tdata", m_tdata, 0);
        chk("rst_m_tlast", m_tlast, 0);

        // Ch1 4-beat packet A0..A3, m_tready=1
        tv[0] = '{4'b0010, 4'b0000, 32'hA0, 4'b0000, 0, 2'd0, 0, 32'h0,  0, 16'd0};
        tv[1] = '{4'b0010, 4'b0000, 32'hA0, 4'b0010, 1, 2'd1, 0, 32'h0,  0, 16'd0};
        tv[2] = '{4'b0010, 4'b0000, 32'hA1, 4'b0010, 1, 2'd1, 1, 32'hA0, 0, 16'd0};
        tv[3] = '{4'b0010, 4'b0000, 32'hA2, 4'b0010, 1, 2'd1, 1, 32'hA1, 0, 16'd0};
        tv[4] = '{4'b0010, 4'b0010, 32'hA3, 4'b0010, 1, 2'd1, 1, 32'hA2, 0, 16'd0};
        tv[5] = '{4'b0000, 4'b0000, 32'h0,  4'b0000, 0, 2'd0, 1, 32'hA3, 1, 16'd0};
        tv[6] = '{4'b0000, 4'b0000, 32'h0,  4'b0000, 0, 2'd0, 0, 32'h0,  0, 16'd1};
        for (int v = 0; v < 7; v++) begin
            s_tvalid = tv[v].vld; s_tlast = tv[v].lst; s_tdata = {4{tv[v].dat}};
            #1;
            chk($sformatf("v%0d_s_tready", v), s_tready, tv[v].srdy);
            chk($sformatf("v%0d_grant_valid", v), grant_valid, tv[v].gv);
            if (tv[v].gv) chk($sformatf("v%0d_grant_ch", v), grant_ch, tv[v].gch);
            chk($sformatf("v%0d_m_tvalid", v), m_tvalid, tv[v].mv);
            if (tv[v].mv) begin
                chk($sformatf("v%0d_m_tdata", v), m_tdata, tv[v].md);
                chk($sformatf("v%0d_m_tlast", v), m_tlast, tv[v].ml);
                chk($sformatf("v%0d_m_tid", v), m_tid, 1);
                chk($sformatf("v%0d_m_tkeep", v), m_tkeep, 4'hF);
            end
            chk($sformatf("v%0d_pkt_cnt", v), pkt_cnt, tv[v].pc);
            tick();
        end

        // All channels with 2-beat packets: order 0,1,2,3,0 with one idle cycle between
        auto_src = 1'b1;
        do_reset();
        for (int c = 0; c < 4; c++) begin en[c] = 1'b1; len[c] = 2; npk[c] = (c == 0) ? 2 : 1; end
        drive_src();
        first_v = -1; last_v = -1;
        k = 0;
        while (q_dat.size() < 10 && k < 100) begin
            if (m_tvalid) begin if (first_v < 0) first_v = cyc; last_v = cyc; end
            tick(); k++;
        end
        chk("rr_timeout", q_dat.size() >= 10, 1);
        for (int p = 0; p < 5; p++) begin
            chk_beat(2 * p, p % 4, p / 4, 0, 0);
            chk_beat(2 * p + 1, p % 4, p / 4, 1, 1);
        end
        chk("rr_span", last_v - first_v, 13);
        chk("rr_pkt_cnt", pkt_cnt, 5);

        // Ch2 8-beat packet under toggling backpressure
        do_reset();
        en[2] = 1'b1; len[2] = 8; npk[2] = 1;
        drive_src();
        for (int i = 0; i < 60 && q_dat.size() < 8; i++) begin
            m_tready = (i % 2 == 0);
            stalled = m_tvalid && !m_tready;
            snap_d = m_tdata; snap_t = m_tid; snap_l = m_tlast;
            tick();
            chk("bp_buf_count_le2", dut.buf_count <= 2'd2, 1);
            if (stalled) begin
                chk("bp_stall_valid", m_tvalid, 1);
                chk("bp_stall_data", m_tdata, snap_d);
                chk("bp_stall_tid", m_tid, snap_t);
                chk("bp_stall_last", m_tlast, snap_l);
            end
        end
        m_tready = 1'b1;
        chk("bp_count", q_dat.size(), 8);
        for (int b = 0; b < 8; b++) chk_beat(b, 2, 0, b, b == 7);

        // Ch0 pauses mid-packet while ch3 waits: grant held until ch0 tlast
        do_reset();
        en[0] = 1'b1; len[0] = 4; npk[0] = 1;
        en[3] = 1'b1; len[3] = 2; npk[3] = 1;
        drive_src();
        k = 0;
        while (beat[0] != 2 && k < 20) begin tick(); k++; end
        chk("hold_reach_timeout", beat[0], 2);
        en[0] = 1'b0;
        drive_src();
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("hold%0d_grant_valid", i), grant_valid, 1);
            chk($sformatf("hold%0d_grant_ch", i), grant_ch, 0);
        end
        en[0] = 1'b1;
        drive_src();
        run_until(6, 40);
        for (int b = 0; b < 4; b++) chk_beat(b, 0, 0, b, b == 3);
        chk_beat(4, 3, 0, 0, 0);
        chk_beat(5, 3, 0, 1, 1);

        // Reset while one beat is buffered mid-packet
        do_reset();
        m_tready = 1'b0;
        en[1] = 1'b1; len[1] = 8; npk[1] = 1;
        drive_src();
        k = 0;
        while (!m_tvalid && k < 10) begin tick(); k++; end
        chk("mrst_buffered", m_tvalid, 1);
        areset = 1'b1;
        tick();
        chk("mrst_m_tvalid", m_tvalid, 0);
        chk("mrst_s_tready", s_tready, 0);
        chk("mrst_pkt_cnt", pkt_cnt, 0);
        chk("mrst_grant_valid", grant_valid, 0);
        areset = 1'b0;
        reset_src();
        q_tid.delete(); q_dat.delete(); q_last.delete();
        m_tready = 1'b1;
        en[0] = 1'b1; len[0] = 3; npk[0] = 1;
        drive_src();
        run_until(3, 30);
        for (int b = 0; b < 3; b++) chk_beat(b, 0, 0, b, b == 2);
        chk("mrst_extra_beats", q_dat.size(), 3);
        chk("mrst_pkt_cnt_after", pkt_cnt, 1);

        // tid passthrough build, single-beat packet timing, pkt_cnt wrap
        do_reset();
        tidv[2] = 4'h9; keepv[2] = 4'h3;
        en[2] = 1'b1; len[2] = 1; npk[2] = 1;
        drive_src();
        k = 0;
        while (!grant_valid && k < 10) begin tick(); k++; end
        chk("sb_grant", grant_valid, 1);
        tick();
        chk("sb_back_to_idle", grant_valid, 0);
        chk("sb_m_tvalid0", m_tvalid0, 1);
        chk("sb_m_tid0", m_tid0, 4'h9);
        chk("sb_m_tkeep0", m_tkeep0, 4'h3);
        chk("sb_m_tstrb0", m_tstrb0, 4'h3);
        chk("sb_m_tdata0", m_tdata0, mkdat(2, 0, 0));
        chk("sb_m_tlast0", m_tlast0, 1);
        chk("sb_m_tid_chid", m_tid, 2);
        tick();
        chk("sb_pkt_cnt0", pkt_cnt0, 1);
        // Preload the counter near the top instead of streaming 65534 packets.
        force dut0.pkt_cnt = 16'hFFFE;
        #1;
        release dut0.pkt_cnt;
        chk("wrap_preload", pkt_cnt0, 16'hFFFE);
        q_tid.delete(); q_dat.delete(); q_last.delete();
        npk[2] = 3;
        drive_src();
        run_until(2, 30);
        chk("wrap_pkt_cnt0", pkt_cnt0, 16'h0000);
        chk("wrap_pkt_cnt", pkt_cnt, 3);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule

// File: doc/axis_rr_mux.md
Name: axis_rr_mux

Overview:
- Parametrised N-to-1 AXI-Stream multiplexer with packet-level round-robin arbitration.
- Merges NUM_CH slave streams into one master stream and passes tdata/tkeep/tstrb/tlast through unchanged.
- Sits between per-channel sample sources and the single DAC data path. Replaces the single-beat, single-channel send flow with full multi-beat packets and backpressure.

Parameters:
- DATA_SIZE, 32, tdata width in bits; multiple of 8.
- ID_SIZE, 4, tid width in bits.
- NUM_CH, 4, number of slave channels; legal range 2..2**ID_SIZE.
- USE_CH_ID, 1, 1 = output tid is the granted channel index (zero-extended); 0 = input tid is passed through.

Ports:
- aclk  in  1  clock; all logic on rising edge.
- areset  in  1  synchronous active-high reset.
- s_tvalid  in  NUM_CH  per-channel valid.
- s_tready  out  NUM_CH  per-channel ready.
- s_tlast  in  NUM_CH  per-channel last.
- s_tdata  in  NUM_CH*DATA_SIZE  channel i occupies bits [i*DATA_SIZE +: DATA_SIZE].
- s_tid  in  NUM_CH*ID_SIZE  packed the same way as s_tdata.
- s_tkeep  in  NUM_CH*DATA_SIZE/8  packed the same way.
- s_tstrb  in  NUM_CH*DATA_SIZE/8  packed the same way.
- m_tvalid, m_tlast  out  1  master valid and last.
- m_tready  in  1  master ready.
- m_tdata  out  DATA_SIZE  master data.
- m_tid  out  ID_SIZE  master id.
- m_tkeep, m_tstrb  out  DATA_SIZE/8  master keep and strobe.
- grant_valid  out  1  high while a channel holds the grant.
- grant_ch  out  $clog2(NUM_CH)  index of the granted channel.
- pkt_cnt  out  16  count of packets completed on the master side.

Behaviour:
- Reset (areset sampled high): all outputs 0, output buffer emptied, FSM to IDLE, last_grant = NUM_CH-1 so channel 0 has first priority. Reset mid-packet discards buffered beats without emitting them; there is no partial-packet recovery.
- FSM states are IDLE and BUSY.
- IDLE:
  - s_tready all 0.
  - If any s_tvalid is high, grant the first valid channel searching last_grant+1, last_grant+2, ... modulo NUM_CH.
  - Next cycle: state BUSY, grant_valid=1, grant_ch=winner, last_grant=winner.
  - The arbitration cycle is one bubble.
- BUSY:
  - s_tready[grant_ch] = (buf_count < 2); all other s_tready bits are 0.
  - Beat accepted when s_tvalid & s_tready of the granted channel are both high.
  - Accepting a beat with s_tlast=1 returns the FSM to IDLE on the next cycle (grant_valid=0).
  - If the granted channel drops s_tvalid mid-packet, the grant is held; no re-arbitration until tlast.
- Output buffer:
  - 2-entry FIFO holding {tdata, tid, tkeep, tstrb, tlast}; outputs are driven from the head entry (registered).
  - m_tvalid = (buf_count != 0).
  - Pop on m_tvalid & m_tready. Push and pop in the same cycle leave the count unchanged.
  - Latency from input acceptance to m_tvalid is 1 cycle. Steady-state throughput is 1 beat/cycle within a packet.
  - s_tready does not depend combinationally on m_tready.
  - While m_tvalid=1 and m_tready=0, all m_* outputs stay stable.
- tid: if USE_CH_ID=1, m_tid = granted index, zero-extended to ID_SIZE; otherwise the input tid is passed through.
- pkt_cnt: increments on each master handshake with m_tlast=1; 16-bit wrap, 0xFFFF -> 0x0000.
- Single-beat packets: a granted single-beat packet is accepted in the first BUSY cycle and the FSM returns to IDLE the following cycle.

Test Plan:
- Ch1 only, 4-beat packet 0xA0..0xA3, m_tready=1 -> grant_ch=1; m_tdata A0..A3 on consecutive cycles; m_tlast on A3; m_tid=1; pkt_cnt=1.
- All 4 channels hold 2-beat packets continuously -> grant order 0,1,2,3,0; one idle master cycle between packets; no beat interleaving.
- Ch2 packet of 8 beats, m_tready toggling 1,0,1,0 -> all 8 beats delivered in order without loss or duplication; m_* stable during stalls; buf_count never exceeds 2.
- Ch0 drops tvalid for 3 cycles mid-packet while ch3 is valid -> grant stays on ch0 until its tlast; ch3 served next.
- areset pulsed while 1 beat is buffered and mid-packet -> next cycle m_tvalid=0, s_tready=0, pkt_cnt=0; a following ch0 packet is delivered intact.
- USE_CH_ID=0, ch2 sends s_tid=0x9 with tkeep=0x3 -> m_tid=0x9 and m_tkeep=0x3; 65536 single-beat packets -> pkt_cnt wraps to 0.
